memory_loader: RTL and testbench

Byte-stream initiator that fills the data memory over its write port (memWrite/address/writeData) at run time, replacing file-based preload. It accepts bytes through a valid/ready handshake, for example from a UART receiver or a JTAG bridge. It packs each group of 4 bytes little-endian into a word and issues one single-cycle word write per group at consecutive word addresses. It sits beside the CPU on the memory write port; the top level muxes it in while busy is high.

---
 rtl/memory_loader.sv | 171 +++++++++++++++++
 tb/tb_memory_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_loader.sv
// memory_loader: byte-stream initiator that fills data memory through its
// word write port. Bytes arrive over a valid/ready handshake. Every four
// bytes are packed little-endian into one word, which is written in a single
// cycle at consecutive word addresses starting at BASE_ADDR.
//
// Optional feature macro: LOADER_CHECKSUM_EN adds a 32-bit wrapping sum of
// all words written in the current load on the checksum output.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; bad word counts answered with an error pulse
// COLLECT | accepting bytes into the assembly register
// WRITE   | one-cycle word write of the assembled word
// DONE    | one-cycle done pulse after the last word
module memory_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] wordCount,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic        byteReady,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic        error
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [11:0] DEPTH_L = 12'(DEPTH_WORDS);

  state_t      state;
  state_t      state_nxt;
  logic [10:0] count_q;
  logic [10:0] word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] asm_q;
  logic        error_q;

  logic count_ok;
  logic start_ok;
  logic start_bad;
  logic byte_xfer;
  logic last_word;

  assign count_ok  = (wordCount != 11'd0) && ({1'b0, wordCount} <= DEPTH_L);
  assign start_ok  = (state == S_IDLE) && start && count_ok;
  assign start_bad = (state == S_IDLE) && start && !count_ok;
  assign byte_xfer = (state == S_COLLECT) && byteValid;
  assign last_word = ((word_idx + 11'd1) == count_q);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        if (byte_xfer && (byte_idx == 2'd3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = last_word ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state, so none of them has a
  // combinational path from the inputs
  always_comb begin
    byteReady = 1'b0;
    memWrite  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    address   = BASE_ADDR;
    writeData = asm_q;
    error     = error_q;
    case (state)
      S_COLLECT: begin
        byteReady = 1'b1;
        busy      = 1'b1;
        address   = BASE_ADDR + {19'd0, word_idx, 2'b00};
      end
      S_WRITE: begin
        memWrite  = 1'b1;
        busy      = 1'b1;
        address   = BASE_ADDR + {19'd0, word_idx, 2'b00};
      end
      S_DONE: begin
        done      = 1'b1;
      end
      default: begin
        byteReady = 1'b0;
      end
    endcase
  end

  // Datapath: count latch, byte/word indices, word assembly, error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 11'd0;
      word_idx <= 11'd0;
      byte_idx <= 2'd0;
      asm_q    <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      error_q <= start_bad;
      if (start_ok) begin
        count_q  <= wordCount;
        word_idx <= 11'd0;
        byte_idx <= 2'd0;
        asm_q    <= 32'd0;
      end
      if (byte_xfer) begin
        case (byte_idx)
          2'd0:    asm_q[7:0]   <= byteData;
          2'd1:    asm_q[15:8]  <= byteData;
          2'd2:    asm_q[23:16] <= byteData;
          default: asm_q[31:24] <= byteData;
        endcase
        byte_idx <= byte_idx + 2'd1;
      end
      if (state == S_WRITE) begin
        word_idx <= word_idx + 11'd1;
        byte_idx <= 2'd0;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of written words; holds its final value until the next load
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= 32'd0;
    end else if (start_ok) begin
      checksum <= 32'd0;
    end else if (state == S_WRITE) begin
      checksum <= checksum + asm_q;
    end
  end
`endif

endmodule

// File: tb/tb_memory_loader.sv
// Testbench for memory_loader: start-acceptance table, directed corner
// sequences and randomized loads checked against a byte-queue model.
module tb_memory_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] wordCount;
  logic        byteValid;
  logic [7:0]  byteData;
  logic        byteReady;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic        error;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  memory_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .wordCount (wordCount),
    .byteValid (byteValid),
    .byteData  (byteData),
    .byteReady (byteReady),
    .memWrite  (memWrite),
    .address   (address),
    .writeData (writeData),
    .busy      (busy),
    .done      (done),
    .error     (error)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  bq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every memory write as the memory would see it
  always @(negedge clk) begin
    if (memWrite) begin
      wr_addr.push_back(address);
      wr_data.push_back(writeData);
      wr_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [10:0] wc;
    logic        exp_err;
    logic        exp_busy;
  } start_vec_t;

  start_vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    byteValid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic [10:0] wc);
    start = 1'b1;
    wordCount = wc;
    @(negedge clk);
    start = 1'b0;
    wordCount = 11'($urandom);
  endtask

  // Offer one byte, optionally after random idle cycles carrying junk data
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard;
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        byteValid = 1'b0;
        byteData = 8'($urandom);
        @(negedge clk);
      end
    end
    byteValid = 1'b1;
    byteData = b;
    guard = 0;
    while (!byteReady && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!byteReady) chk("byte_ready_timeout", 32'(byteReady), 32'd1);
    @(negedge clk);
    byteValid = 1'b0;
    byteData = 8'($urandom);
  endtask

  task automatic wait_done(output int dcyc);
    int guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    dcyc = cyc;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] model_word(input int i);
    return 32'(bq[4*i]) + 32'(bq[4*i+1]) * 32'd256 +
           32'(bq[4*i+2]) * 32'd65536 + 32'(bq[4*i+3]) * 32'd16777216;
  endfunction

  task automatic check_writes(input int nexp);
    chk("write_count", 32'(wr_data.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < wr_data.size(); i++) begin
      chk("write_addr", wr_addr[i], BASE + 32'(4 * i));
      chk("write_data", wr_data[i], model_word(i));
    end
  endtask

  task automatic run_load(input bit stall);
    int n;
    int dcyc;
    logic [31:0] sum;
    n = bq.size() / 4;
    clear_log();
    pulse_start(11'(n));
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("ready_after_start", 32'(byteReady), 32'd1);
    foreach (bq[i]) send_byte(bq[i], stall);
    wait_done(dcyc);
    check_writes(n);
    if (wr_cyc.size() > 0) chk("done_latency", 32'(dcyc), 32'(wr_cyc[wr_cyc.size()-1] + 1));
    sum = 32'd0;
    for (int i = 0; i < n; i++) sum = sum + model_word(i);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
  endtask

  initial begin
    int dcyc;
    reset = 1'b1;
    start = 1'b0;
    wordCount = 11'd0;
    byteValid = 1'b0;
    byteData = 8'd0;

    vecs[0] = '{11'd0,    1'b1, 1'b0};
    vecs[1] = '{11'd1025, 1'b1, 1'b0};
    vecs[2] = '{11'd2047, 1'b1, 1'b0};
    vecs[3] = '{11'd1,    1'b0, 1'b1};
    vecs[4] = '{11'd1024, 1'b0, 1'b1};
    vecs[5] = '{11'd512,  1'b0, 1'b1};

    do_reset();
    chk("rst_byteReady", 32'(byteReady), 32'd0);
    chk("rst_memWrite", 32'(memWrite), 32'd0);
    chk("rst_address", address, BASE);
    chk("rst_writeData", writeData, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);

    // Start acceptance over the word-count range
    for (int v = 0; v < 6; v++) begin
      do_reset();
      clear_log();
      pulse_start(vecs[v].wc);
      chk("vec_error", 32'(error), 32'(vecs[v].exp_err));
      chk("vec_busy", 32'(busy), 32'(vecs[v].exp_busy));
      chk("vec_ready", 32'(byteReady), 32'(vecs[v].exp_busy));
      @(negedge clk);
      chk("vec_error_pulse", 32'(error), 32'd0);
      chk("vec_no_write", 32'(wr_data.size()), 32'd0);
    end
    do_reset();

    // Single word
    bq = '{8'h78, 8'h56, 8'h34, 8'h12};
    run_load(1'b0);
    if (wr_data.size() > 0) chk("single_word", wr_data[0], 32'h1234_5678);

    // Burst with stalls
    bq.delete();
    for (int i = 0; i < 12; i++) bq.push_back(8'(i));
    run_load(1'b1);
    if (wr_data.size() == 3) begin
      chk("burst_w0", wr_data[0], 32'h0302_0100);
      chk("burst_w1", wr_data[1], 32'h0706_0504);
      chk("burst_w2", wr_data[2], 32'h0B0A_0908);
    end

    // Reset mid-word, with start and a byte offered on the reset edge
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    clear_log();
    pulse_start(11'd2);
    for (int i = 0; i < 6; i++) send_byte(bq[i], 1'b0);
    reset = 1'b1;
    start = 1'b1;
    wordCount = 11'd1;
    byteValid = 1'b1;
    byteData = 8'hAA;
    @(negedge clk);
    chk("mid_rst_byteReady", 32'(byteReady), 32'd0);
    chk("mid_rst_memWrite", 32'(memWrite), 32'd0);
    chk("mid_rst_address", address, BASE);
    chk("mid_rst_writeData", writeData, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    byteValid = 1'b0;
    repeat (8) @(negedge clk);
    check_writes(1);
    chk("mid_rst_idle", 32'(busy), 32'd0);
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(1'b1);

    // Start while busy is ignored
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
    clear_log();
    pulse_start(11'd2);
    send_byte(bq[0], 1'b0);
    start = 1'b1;
    wordCount = 11'd1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 8; i++) send_byte(bq[i], 1'b1);
    wait_done(dcyc);
    check_writes(2);

`ifdef LOADER_CHECKSUM_EN
    bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    run_load(1'b0);
    chk("checksum_wrap", checksum, 32'h0000_0001);
`endif

    // Randomized loads
    repeat (6) begin
      int n;
      n = $urandom_range(1, 5);
      bq.delete();
      for (int i = 0; i < 4 * n; i++) bq.push_back(8'($urandom));
      run_load(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
